// File: rtl/qcw_controller_if.sv
// Board-side signal bundle of the QCW controller: ADC link, output bus, debug header.
// master = controller side, slave = board/bench side.
interface qcw_controller_if;
  logic        ADC_BIT_CLK;
  logic        ADC_BIT_CLK_N;
  logic        ADC_FRAME_CLK;
  logic        ADC_FRAME_CLK_N;
  logic [7:0]  ADC_DATA;
  logic [7:0]  ADC_DATA_N;
  logic        ADC_CS;
  logic        ADC_SCLK;
  logic        ADC_SDATA;
  logic        ADC_RESET;
  logic        ADC_PDN;
  logic        ADC_MUX;
  logic        ADC_SYNC;
  logic [11:0] OUTPUT_BUS;
  logic        DEBUG_BUS_A;
  logic        DEBUG_BUS_B;
  logic        DEBUG_BUS_C;
  logic        DEBUG_BUS_D;
  logic        DEBUG_BUS_E;

  modport master (
    input  ADC_BIT_CLK, ADC_BIT_CLK_N, ADC_FRAME_CLK, ADC_FRAME_CLK_N, ADC_DATA, ADC_DATA_N,
    input  DEBUG_BUS_B, DEBUG_BUS_D,
    output ADC_CS, ADC_SCLK, ADC_SDATA, ADC_RESET, ADC_PDN, ADC_MUX, ADC_SYNC,
    output OUTPUT_BUS, DEBUG_BUS_A, DEBUG_BUS_C, DEBUG_BUS_E
  );

  modport slave (
    output ADC_BIT_CLK, ADC_BIT_CLK_N, ADC_FRAME_CLK, ADC_FRAME_CLK_N, ADC_DATA, ADC_DATA_N,
    output DEBUG_BUS_B, DEBUG_BUS_D,
    input  ADC_CS, ADC_SCLK, ADC_SDATA, ADC_RESET, ADC_PDN, ADC_MUX, ADC_SYNC,
    input  OUTPUT_BUS, DEBUG_BUS_A, DEBUG_BUS_C, DEBUG_BUS_E
  );
endinterface

// File: rtl/qcw_controller_top.sv
// QCW driver controller: UART register access, 12-bit output bus, GPIO, ADC SPI sequencer.
// Optional macro ADC_CAPTURE_EN adds ADC sample-byte capture (register 0x7).
module qcw_controller_top #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int SPI_HALF = 8
) (
  input logic              FPGA_CLK,
  input logic              FPGA_RESET,
  qcw_controller_if.master hw
);
  localparam int          DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [15:0] SPI_M1  = 16'(SPI_HALF - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {SPI_IDLE, SPI_SETUP, SPI_SHIFT, SPI_HOLD} spi_state_t;

  logic [1:0]  rx_sync_r, gpio_sync_r;
  rx_state_t   rx_state_r, rx_state_nxt;
  logic [15:0] rx_cnt_r, rx_cnt_nxt;
  logic [2:0]  rx_bit_r, rx_bit_nxt;
  logic [7:0]  rx_sh_r, rx_sh_nxt;
  logic        rx_valid_s, rx_ferr_s, rx_s;
  logic        expect_data_r;
  logic [3:0]  wr_addr_r, ctrl_r, rst_cnt_r;
  logic [7:0]  out_lo_r, out_hi_r, spi_addr_r, spi_dhi_r, spi_dlo_r, rd_data_s, sample_s;
  logic [11:0] out_bus_r;
  logic        ferr_r, adc_reset_r, adc_sync_r, clk_out_r;
  logic        wr_en_s, rd_go_s, spi_busy_s, spi_start_s;
  logic [9:0]  tx_sh_r;
  logic [15:0] tx_cnt_r;
  logic [3:0]  tx_bits_r;
  logic        tx_busy_r, tx_out_r;
  spi_state_t  spi_state_r, spi_state_nxt;
  logic [15:0] spi_tick_r, spi_tick_nxt;
  logic [5:0]  spi_half_r, spi_half_nxt;
  logic [23:0] spi_sh_r, spi_sh_nxt;
  logic        spi_cs_r, spi_sclk_r, spi_sdata_r;

  assign rx_s        = rx_sync_r[1];
  assign wr_en_s     = rx_valid_s && expect_data_r;
  assign rd_go_s     = rx_valid_s && !expect_data_r && !rx_sh_r[7] && !tx_busy_r;
  assign spi_busy_s  = (spi_state_r != SPI_IDLE);
  assign spi_start_s = wr_en_s && (wr_addr_r == 4'h5) && !spi_busy_s;

  // Two-stage synchronizers for the asynchronous UART RX and GPIO inputs.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      rx_sync_r   <= 2'b11;
      gpio_sync_r <= 2'b00;
    end else begin
      rx_sync_r   <= {rx_sync_r[0], hw.DEBUG_BUS_B};
      gpio_sync_r <= {gpio_sync_r[0], hw.DEBUG_BUS_D};
    end
  end

  // UART receiver state register.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_sh_r    <= 8'h00;
    end else begin
      rx_state_r <= rx_state_nxt;
      rx_cnt_r   <= rx_cnt_nxt;
      rx_bit_r   <= rx_bit_nxt;
      rx_sh_r    <= rx_sh_nxt;
    end
  end

  // UART receiver next state: mid-bit sampling, a glitchy start is rejected, a low stop bit waits for idle.
  always_comb begin
    rx_state_nxt = rx_state_r;
    rx_cnt_nxt   = rx_cnt_r + 16'd1;
    rx_bit_nxt   = rx_bit_r;
    rx_sh_nxt    = rx_sh_r;
    rx_valid_s   = 1'b0;
    rx_ferr_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_nxt = 16'd0;
        if (!rx_s) rx_state_nxt = RX_START;
        else       rx_state_nxt = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_M1) begin
          rx_cnt_nxt   = 16'd0;
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == DIV_M1) begin
          rx_cnt_nxt = 16'd0;
          rx_sh_nxt  = {rx_s, rx_sh_r[7:1]};
          rx_bit_nxt = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_nxt = RX_STOP;
          else                  rx_state_nxt = RX_DATA;
        end else begin
          rx_state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == DIV_M1) begin
          rx_cnt_nxt   = 16'd0;
          rx_valid_s   = rx_s;
          rx_ferr_s    = !rx_s;
          rx_state_nxt = rx_s ? RX_IDLE : RX_BREAK;
        end else begin
          rx_state_nxt = RX_STOP;
        end
      end
      RX_BREAK: begin
        rx_cnt_nxt = 16'd0;
        if (rx_s) rx_state_nxt = RX_IDLE;
        else      rx_state_nxt = RX_BREAK;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Command parser, register file, ADC reset/sync pulses and clock-out divider.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      expect_data_r <= 1'b0;
      wr_addr_r     <= 4'h0;
      ctrl_r        <= 4'b0001;
      out_lo_r      <= 8'h00;
      out_hi_r      <= 8'h00;
      out_bus_r     <= 12'h000;
      spi_addr_r    <= 8'h00;
      spi_dhi_r     <= 8'h00;
      spi_dlo_r     <= 8'h00;
      ferr_r        <= 1'b0;
      adc_sync_r    <= 1'b0;
      adc_reset_r   <= 1'b0;
      rst_cnt_r     <= 4'd0;
      clk_out_r     <= 1'b0;
    end else begin
      if (rx_ferr_s) begin
        expect_data_r <= 1'b0;
      end else if (rx_valid_s && !expect_data_r && rx_sh_r[7]) begin
        expect_data_r <= 1'b1;
        wr_addr_r     <= rx_sh_r[3:0];
      end else if (rx_valid_s) begin
        expect_data_r <= 1'b0;
      end
      if (wr_en_s) begin
        case (wr_addr_r)
          4'h0: ctrl_r   <= rx_sh_r[3:0];
          4'h1: out_lo_r <= rx_sh_r;
          4'h2: begin
            out_hi_r  <= rx_sh_r;
            out_bus_r <= {rx_sh_r[3:0], out_lo_r};
          end
          4'h3: if (!spi_busy_s) spi_addr_r <= rx_sh_r;
          4'h4: if (!spi_busy_s) spi_dhi_r  <= rx_sh_r;
          4'h5: if (!spi_busy_s) spi_dlo_r  <= rx_sh_r;
          default: ;
        endcase
      end
      if (rx_ferr_s)                               ferr_r <= 1'b1;
      else if (rd_go_s && rx_sh_r[3:0] == 4'h6)    ferr_r <= 1'b0;
      adc_sync_r <= wr_en_s && (wr_addr_r == 4'h0) && rx_sh_r[5];
      // Reset pulse: high for the trigger cycle plus 15 countdown cycles; a re-trigger restarts it.
      if (wr_en_s && (wr_addr_r == 4'h0) && rx_sh_r[4]) begin
        adc_reset_r <= 1'b1;
        rst_cnt_r   <= 4'd15;
      end else if (rst_cnt_r != 4'd0) begin
        rst_cnt_r   <= rst_cnt_r - 4'd1;
      end else begin
        adc_reset_r <= 1'b0;
      end
      clk_out_r <= ctrl_r[3] ? !clk_out_r : 1'b0;
    end
  end

  // Read-back mux addressed by the command byte currently completing.
  always_comb begin
    rd_data_s = 8'h00;
    case (rx_sh_r[3:0])
      4'h0:    rd_data_s = {4'h0, ctrl_r};
      4'h1:    rd_data_s = out_lo_r;
      4'h2:    rd_data_s = out_hi_r;
      4'h3:    rd_data_s = spi_addr_r;
      4'h4:    rd_data_s = spi_dhi_r;
      4'h5:    rd_data_s = spi_dlo_r;
      4'h6:    rd_data_s = {5'b00000, ferr_r, gpio_sync_r[1], spi_busy_s};
      4'h7:    rd_data_s = sample_s;
      4'h8:    rd_data_s = 8'h51;
      default: rd_data_s = 8'h00;
    endcase
  end

  // UART transmitter: start bit is driven on the same edge the read is accepted.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      tx_busy_r <= 1'b0;
      tx_out_r  <= 1'b1;
      tx_sh_r   <= 10'h3FF;
      tx_cnt_r  <= 16'd0;
      tx_bits_r <= 4'd0;
    end else if (rd_go_s) begin
      tx_busy_r <= 1'b1;
      tx_out_r  <= 1'b0;
      tx_sh_r   <= {1'b1, rd_data_s, 1'b0};
      tx_cnt_r  <= 16'd0;
      tx_bits_r <= 4'd0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == DIV_M1) begin
        tx_cnt_r <= 16'd0;
        if (tx_bits_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          tx_out_r  <= 1'b1;
        end else begin
          tx_bits_r <= tx_bits_r + 4'd1;
          tx_sh_r   <= {1'b1, tx_sh_r[9:1]};
          tx_out_r  <= tx_sh_r[1];
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + 16'd1;
      end
    end
  end

  // SPI sequencer state register and registered pin drivers.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      spi_state_r <= SPI_IDLE;
      spi_tick_r  <= 16'd0;
      spi_half_r  <= 6'd0;
      spi_sh_r    <= 24'h000000;
      spi_cs_r    <= 1'b1;
      spi_sclk_r  <= 1'b0;
      spi_sdata_r <= 1'b0;
    end else begin
      spi_state_r <= spi_state_nxt;
      spi_tick_r  <= spi_tick_nxt;
      spi_half_r  <= spi_half_nxt;
      spi_sh_r    <= spi_sh_nxt;
      spi_cs_r    <= (spi_state_nxt == SPI_IDLE);
      spi_sclk_r  <= (spi_state_nxt == SPI_SHIFT) && spi_half_nxt[0];
      spi_sdata_r <= (spi_state_nxt == SPI_IDLE) ? 1'b0 : spi_sh_nxt[23];
    end
  end

  // SPI next state: SETUP, 48 half periods (SCLK high in odd halves, shift after each), HOLD.
  always_comb begin
    spi_state_nxt = spi_state_r;
    spi_tick_nxt  = spi_tick_r + 16'd1;
    spi_half_nxt  = spi_half_r;
    spi_sh_nxt    = spi_sh_r;
    case (spi_state_r)
      SPI_IDLE: begin
        spi_tick_nxt = 16'd0;
        if (spi_start_s) begin
          spi_state_nxt = SPI_SETUP;
          spi_sh_nxt    = {spi_addr_r, spi_dhi_r, rx_sh_r};
        end else begin
          spi_state_nxt = SPI_IDLE;
        end
      end
      SPI_SETUP: begin
        if (spi_tick_r == SPI_M1) begin
          spi_tick_nxt  = 16'd0;
          spi_half_nxt  = 6'd0;
          spi_state_nxt = SPI_SHIFT;
        end else begin
          spi_state_nxt = SPI_SETUP;
        end
      end
      SPI_SHIFT: begin
        if (spi_tick_r == SPI_M1) begin
          spi_tick_nxt = 16'd0;
          if (spi_half_r[0]) spi_sh_nxt = {spi_sh_r[22:0], 1'b0};
          else               spi_sh_nxt = spi_sh_r;
          if (spi_half_r == 6'd47) spi_state_nxt = SPI_HOLD;
          else                     spi_half_nxt  = spi_half_r + 6'd1;
        end else begin
          spi_state_nxt = SPI_SHIFT;
        end
      end
      SPI_HOLD: begin
        if (spi_tick_r == SPI_M1) begin
          spi_tick_nxt  = 16'd0;
          spi_state_nxt = SPI_IDLE;
        end else begin
          spi_state_nxt = SPI_HOLD;
        end
      end
      default: spi_state_nxt = SPI_IDLE;
    endcase
  end

`ifdef ADC_CAPTURE_EN
  logic [2:0] frame_sync_r;
  logic [7:0] data_sync0_r, data_sync1_r, sample_r;
  logic       unused_s;
  assign unused_s = ^{hw.ADC_BIT_CLK, hw.ADC_BIT_CLK_N, hw.ADC_FRAME_CLK_N, hw.ADC_DATA_N};
  assign sample_s = sample_r;

  // Capture the synchronized ADC byte on each synchronized frame-clock rising edge.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RESET) begin
      frame_sync_r <= 3'b000;
      data_sync0_r <= 8'h00;
      data_sync1_r <= 8'h00;
      sample_r     <= 8'h00;
    end else begin
      frame_sync_r <= {frame_sync_r[1:0], hw.ADC_FRAME_CLK};
      data_sync0_r <= hw.ADC_DATA;
      data_sync1_r <= data_sync0_r;
      if (frame_sync_r[1] && !frame_sync_r[2]) sample_r <= data_sync1_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{hw.ADC_BIT_CLK, hw.ADC_BIT_CLK_N, hw.ADC_FRAME_CLK, hw.ADC_FRAME_CLK_N,
                      hw.ADC_DATA, hw.ADC_DATA_N};
  assign sample_s = 8'h00;
`endif

  assign hw.ADC_CS      = spi_cs_r;
  assign hw.ADC_SCLK    = spi_sclk_r;
  assign hw.ADC_SDATA   = spi_sdata_r;
  assign hw.ADC_RESET   = adc_reset_r;
  assign hw.ADC_PDN     = ctrl_r[0];
  assign hw.ADC_MUX     = ctrl_r[1];
  assign hw.ADC_SYNC    = adc_sync_r;
  assign hw.OUTPUT_BUS  = out_bus_r;
  assign hw.DEBUG_BUS_A = tx_out_r;
  assign hw.DEBUG_BUS_C = ctrl_r[2];
  assign hw.DEBUG_BUS_E = clk_out_r;
endmodule

// File: tb/tb_qcw_controller_top.sv
// Self-checking bench for qcw_controller_top: directed register/SPI/pulse checks plus
// randomized register traffic compared against a register-level reference model.
module tb_qcw_controller_top;
  localparam int CLK_HZ   = 50000000;
  localparam int BAUD     = 3125000;   // divisor 16 keeps UART frames short
  localparam int SPI_HALF = 16;
  localparam int DIV      = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  qcw_controller_if hw ();

  qcw_controller_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SPI_HALF(SPI_HALF)) dut (
    .FPGA_CLK   (clk),
    .FPGA_RESET (rst),
    .hw         (hw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the register file.
  logic [3:0]  m_ctrl;
  logic [7:0]  m_lo, m_hi, m_sa, m_sh, m_sl, m_sample;
  logic [11:0] m_bus;
  logic        m_gpio;

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return {4'h0, m_ctrl};
      4'h1: return m_lo;
      4'h2: return m_hi;
      4'h3: return m_sa;
      4'h4: return m_sh;
      4'h5: return m_sl;
      4'h6: return {6'b000000, m_gpio, 1'b0};
      4'h7: return m_sample;
      4'h8: return 8'h51;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    hw.DEBUG_BUS_B = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      hw.DEBUG_BUS_B = b[i];
      repeat (DIV) @(negedge clk);
    end
    hw.DEBUG_BUS_B = stop;
    repeat (DIV) @(negedge clk);
    hw.DEBUG_BUS_B = 1'b1;
    repeat (stop ? 2 : 3 * DIV) @(negedge clk);
  endtask

  task automatic uart_recv(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 30 * DIV; i++) begin
      @(posedge clk); #1;
      if (hw.DEBUG_BUS_A == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (DIV / 2) @(posedge clk);
      #1;
      if (hw.DEBUG_BUS_A != 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        #1;
        b[i] = hw.DEBUG_BUS_A;
      end
      repeat (DIV) @(posedge clk);
      #1;
      if (hw.DEBUG_BUS_A != 1'b1) ok = 1'b0;
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    uart_send({4'h8, a}, 1'b1);
    uart_send(d, 1'b1);
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    logic ok;
    fork
      uart_send({4'h0, a}, 1'b1);
      uart_recv(d, ok);
    join
    check_eq("uart_response_framed", 32'(ok), 32'd1);
  endtask

  // Watches one SPI transfer: CS-low length, bits captured on SCLK rises, illegal SDATA moves.
  task automatic spi_monitor(output int low, output int rises, output logic [23:0] cap,
                             output int bad, output logic timeout);
    logic prev_sclk, prev_sdata;
    low = 0; rises = 0; cap = 24'h0; bad = 0; timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (hw.ADC_CS == 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      prev_sclk  = hw.ADC_SCLK;
      prev_sdata = hw.ADC_SDATA;
      low = 1;
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk); #1;
        if (hw.ADC_CS != 1'b0) break;
        low++;
        if (hw.ADC_SCLK && !prev_sclk) begin
          rises++;
          cap = {cap[22:0], hw.ADC_SDATA};
        end
        if ((hw.ADC_SDATA != prev_sdata) && !(prev_sclk && !hw.ADC_SCLK)) bad++;
        prev_sclk  = hw.ADC_SCLK;
        prev_sdata = hw.ADC_SDATA;
      end
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0]  rd;
    logic [23:0] cap;
    int          low, rises, bad, extra, hi_cnt, sync_cnt, tog;
    logic        tmo, prev;
    logic [3:0]  a;
    logic [7:0]  d;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    hw.ADC_BIT_CLK = 1'b0;  hw.ADC_BIT_CLK_N = 1'b0;
    hw.ADC_FRAME_CLK = 1'b0; hw.ADC_FRAME_CLK_N = 1'b0;
    hw.ADC_DATA = 8'h00;    hw.ADC_DATA_N = 8'h00;
    hw.DEBUG_BUS_B = 1'b1;  hw.DEBUG_BUS_D = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset values
    check_eq("rst_cs",    32'(hw.ADC_CS), 32'd1);
    check_eq("rst_sclk",  32'(hw.ADC_SCLK), 32'd0);
    check_eq("rst_sdata", 32'(hw.ADC_SDATA), 32'd0);
    check_eq("rst_adcrst",32'(hw.ADC_RESET), 32'd0);
    check_eq("rst_pdn",   32'(hw.ADC_PDN), 32'd1);
    check_eq("rst_mux",   32'(hw.ADC_MUX), 32'd0);
    check_eq("rst_sync",  32'(hw.ADC_SYNC), 32'd0);
    check_eq("rst_bus",   32'(hw.OUTPUT_BUS), 32'h000);
    check_eq("rst_tx",    32'(hw.DEBUG_BUS_A), 32'd1);
    check_eq("rst_gpio",  32'(hw.DEBUG_BUS_C), 32'd0);
    check_eq("rst_clkout",32'(hw.DEBUG_BUS_E), 32'd0);

    read_reg(4'h8, rd); check_eq("read_id", 32'(rd), 32'h51);
    read_reg(4'h0, rd); check_eq("read_ctrl_rst", 32'(rd), 32'h01);

    // Staged output bus
    write_reg(4'h1, 8'hA5);
    check_eq("bus_staged", 32'(hw.OUTPUT_BUS), 32'h000);
    write_reg(4'h2, 8'hF3);
    check_eq("bus_applied", 32'(hw.OUTPUT_BUS), 32'h3A5);

    // SPI transfer, ignored second trigger, busy status
    write_reg(4'h3, 8'h12);
    write_reg(4'h4, 8'h34);
    fork
      begin
        write_reg(4'h5, 8'h56);
        write_reg(4'h5, 8'h99);
        read_reg(4'h6, rd);
      end
      spi_monitor(low, rises, cap, bad, tmo);
    join
    check_eq("spi_start_timeout", 32'(tmo), 32'd0);
    check_eq("spi_cs_low_cycles", 32'(low), 32'(50 * SPI_HALF));
    check_eq("spi_sclk_rises", 32'(rises), 32'd24);
    check_eq("spi_word", 32'(cap), 32'h123456);
    check_eq("spi_sdata_moves", 32'(bad), 32'd0);
    check_eq("status_busy", 32'(rd), 32'h03);
    extra = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (hw.ADC_CS == 1'b0) extra++;
    end
    check_eq("spi_no_extra", 32'(extra), 32'd0);
    read_reg(4'h5, rd); check_eq("spi_dlo_kept", 32'(rd), 32'h56);

    // ADC reset pulse and clock-out
    fork
      write_reg(4'h0, 8'h19);
      begin
        hi_cnt = 0; tmo = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk); #1;
          if (hw.ADC_RESET) begin tmo = 1'b0; break; end
        end
        if (!tmo) begin
          hi_cnt = 1;
          for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!hw.ADC_RESET) break;
            hi_cnt++;
          end
        end
      end
    join
    check_eq("adc_reset_timeout", 32'(tmo), 32'd0);
    check_eq("adc_reset_len", 32'(hi_cnt), 32'd16);
    tog = 0;
    prev = hw.DEBUG_BUS_E;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (hw.DEBUG_BUS_E != prev) tog++;
      prev = hw.DEBUG_BUS_E;
    end
    check_eq("clkout_toggles", 32'(tog), 32'd8);
    check_eq("gpio_out_low", 32'(hw.DEBUG_BUS_C), 32'd0);
    read_reg(4'h0, rd); check_eq("ctrl_0x09", 32'(rd), 32'h09);

    // Single-cycle sync pulse
    sync_cnt = 0;
    fork
      write_reg(4'h0, 8'h29);
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        if (hw.ADC_SYNC) sync_cnt++;
      end
    join
    check_eq("sync_pulse_len", 32'(sync_cnt), 32'd1);

    // Framing error: data byte discarded, sticky status cleared by reading
    uart_send(8'h81, 1'b1);
    uart_send(8'h77, 1'b0);
    read_reg(4'h6, rd); check_eq("status_ferr_set", 32'(rd), 32'h06);
    read_reg(4'h6, rd); check_eq("status_ferr_clr", 32'(rd), 32'h02);
    read_reg(4'h1, rd); check_eq("ferr_no_write", 32'(rd), 32'hA5);

    // ADC sample capture
    hw.ADC_DATA = 8'h3C;
    repeat (10) @(negedge clk);
    hw.ADC_FRAME_CLK = 1'b1;
    repeat (10) @(negedge clk);
    hw.ADC_FRAME_CLK = 1'b0;
    read_reg(4'h7, rd);
`ifdef ADC_CAPTURE_EN
    check_eq("adc_sample", 32'(rd), 32'h3C);
`else
    check_eq("adc_sample", 32'(rd), 32'h00);
`endif

    // Reset in the middle of a transfer
    write_reg(4'h5, 8'hC3);
    repeat (100) @(negedge clk);
    check_eq("spi_mid_cs", 32'(hw.ADC_CS), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_cs", 32'(hw.ADC_CS), 32'd1);
    check_eq("abort_sclk", 32'(hw.ADC_SCLK), 32'd0);
    check_eq("abort_sdata", 32'(hw.ADC_SDATA), 32'd0);
    check_eq("abort_bus", 32'(hw.OUTPUT_BUS), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(4'h5, rd); check_eq("abort_dlo", 32'(rd), 32'h00);

    // Randomized register traffic against the model
    m_ctrl = 4'h1; m_lo = 8'h00; m_hi = 8'h00; m_sa = 8'h00; m_sh = 8'h00; m_sl = 8'h00;
    m_bus = 12'h000; m_sample = 8'h00; m_gpio = 1'b1;
    for (int k = 0; k < 48; k++) begin
      m_gpio = 1'($urandom_range(0, 1));
      hw.DEBUG_BUS_D = m_gpio;
      repeat (4) @(negedge clk);
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (a == 4'h5) a = 4'h4;
        write_reg(a, d);
        case (a)
          4'h0: m_ctrl = d[3:0];
          4'h1: m_lo = d;
          4'h2: begin m_hi = d; m_bus = {d[3:0], m_lo}; end
          4'h3: m_sa = d;
          4'h4: m_sh = d;
          default: ;
        endcase
        check_eq("rnd_bus", 32'(hw.OUTPUT_BUS), 32'(m_bus));
        check_eq("rnd_pins", 32'({hw.DEBUG_BUS_C, hw.ADC_MUX, hw.ADC_PDN}), 32'(m_ctrl[2:0]));
      end else begin
        read_reg(a, rd);
        check_eq("rnd_read", 32'(rd), 32'(model_read(a)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
